// File: rtl/n2_dta_pkg.sv
// Shared widths, fill-queue entry type and helpers for the D-cache tag array access controller.
package n2_dta_pkg;

  localparam int IDX_W       = 7;
  localparam int TAG_W       = 30;
  localparam int NWAYS       = 4;
  localparam int WAY_W       = 2;
  localparam int TAG_VLD_BIT = 29;
  localparam int PTAG_W      = TAG_VLD_BIT;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [WAY_W-1:0] way;
    logic [TAG_W-1:0] tag;
  } dta_fill_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_READ  = 2'd1,
    ARB_WRITE = 2'd2
  } arb_op_e;

  function automatic logic [2:0] popcnt_ways(input logic [NWAYS-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NWAYS; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/n2_dta_access_ctl_if.sv
// Load-pipe, fill and tag-array signal bundle of the tag array access controller.
interface n2_dta_access_ctl_if;
  import n2_dta_pkg::*;

  logic              lookup_vld;
  logic [IDX_W-1:0]  lookup_idx;
  logic [PTAG_W-1:0] lookup_ptag;
  logic              lookup_rdy;

  logic              fill_vld;
  logic [IDX_W-1:0]  fill_idx;
  logic [WAY_W-1:0]  fill_way;
  logic [TAG_W-1:0]  fill_tag;
  logic              fill_rdy;

  logic [IDX_W-1:0]  dta_index0_x;
  logic [IDX_W-1:0]  dta_index1_x;
  logic              dta_index_sel_x;
  logic [WAY_W-1:0]  dta_wrway_x;
  logic              dta_rdreq_x;
  logic              dta_wrreq_x;
  logic [TAG_W-1:0]  dta_wrtag_x;
  logic              dta_clken;

  logic [TAG_W-1:0]  dta_rdtag_w0_y;
  logic [TAG_W-1:0]  dta_rdtag_w1_y;
  logic [TAG_W-1:0]  dta_rdtag_w2_y;
  logic [TAG_W-1:0]  dta_rdtag_w3_y;

  logic              hit_vld_m;
  logic [NWAYS-1:0]  hit_way_m;
  logic              hit_m;
  logic              multihit_err_m;

  // Requester side: load pipe, fill source and the tag array itself.
  modport master (
    output lookup_vld, lookup_idx, lookup_ptag,
    input  lookup_rdy,
    output fill_vld, fill_idx, fill_way, fill_tag,
    input  fill_rdy,
    input  dta_index0_x, dta_index1_x, dta_index_sel_x, dta_wrway_x,
    input  dta_rdreq_x, dta_wrreq_x, dta_wrtag_x, dta_clken,
    output dta_rdtag_w0_y, dta_rdtag_w1_y, dta_rdtag_w2_y, dta_rdtag_w3_y,
    input  hit_vld_m, hit_way_m, hit_m, multihit_err_m
  );

  modport slave (
    input  lookup_vld, lookup_idx, lookup_ptag,
    output lookup_rdy,
    input  fill_vld, fill_idx, fill_way, fill_tag,
    output fill_rdy,
    output dta_index0_x, dta_index1_x, dta_index_sel_x, dta_wrway_x,
    output dta_rdreq_x, dta_wrreq_x, dta_wrtag_x, dta_clken,
    input  dta_rdtag_w0_y, dta_rdtag_w1_y, dta_rdtag_w2_y, dta_rdtag_w3_y,
    output hit_vld_m, hit_way_m, hit_m, multihit_err_m
  );

endinterface

// File: rtl/n2_dta_fillq.sv
// Small FIFO of pending tag writes; also reports which valid entries target a given set index.
module n2_dta_fillq
  import n2_dta_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  dta_fill_t        push_data,
  input  logic             pop,
  input  logic [IDX_W-1:0] match_idx,
  output dta_fill_t        head,
  output logic             full,
  output logic             empty,
  output logic [DEPTH-1:0] idx_match
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  dta_fill_t        mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en, rd_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;

  // Push and pop slots can only coincide when empty or full, where one of them is blocked.
  always_comb begin
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (rd_en) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = ptr_inc(rd_ptr_q);
    end
    cnt_d = cnt_q + CNT_W'(wr_en) - CNT_W'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign idx_match[gi] = vld_q[gi] & (mem_q[gi].idx == match_idx);
    end
  endgenerate

endmodule

// File: rtl/n2_dta_access_ctl.sv
// Tag array access controller: lookup/fill arbitration, flopped array requests, staged 4-way compare.
module n2_dta_access_ctl
  import n2_dta_pkg::*;
#(
  parameter int FQ_DEPTH   = 2,
  parameter int STARVE_MAX = 8
) (
  input logic                l2clk,
  input logic                reset,
  n2_dta_access_ctl_if.slave bus
);

  localparam int STV_W = $clog2(STARVE_MAX + 1);

  dta_fill_t           fq_head, fq_wdata;
  logic                fq_full, fq_empty;
  logic [FQ_DEPTH-1:0] fq_idx_match;
  logic                hazard, force_wr, lookup_rdy_c;
  arb_op_e             op;

  logic [STV_W-1:0]  starve_q, starve_d;
  logic              rdreq_q, rdreq_d;
  logic              wrreq_q, wrreq_d;
  logic              clken_q, clken_d;
  logic [IDX_W-1:0]  index0_q, index0_d;
  logic [IDX_W-1:0]  index1_q, index1_d;
  logic [WAY_W-1:0]  wrway_q, wrway_d;
  logic [TAG_W-1:0]  wrtag_q, wrtag_d;
  logic [PTAG_W-1:0] ptag_x_q, ptag_x_d;
  logic              rd_y_q, rd_y_d;
  logic [PTAG_W-1:0] ptag_y_q, ptag_y_d;
  logic              hit_vld_q, hit_vld_d;
  logic [NWAYS-1:0]  hit_way_q, hit_way_d;
  logic              hit_q, hit_d;
  logic              multihit_q, multihit_d;

  logic [TAG_W-1:0]  rdtag_y [NWAYS];
  logic [NWAYS-1:0]  way_match;
  logic [2:0]        match_cnt;

  assign fq_wdata = '{idx: bus.fill_idx, way: bus.fill_way, tag: bus.fill_tag};

  n2_dta_fillq #(
    .DEPTH (FQ_DEPTH)
  ) u_fillq (
    .clk       (l2clk),
    .srst      (reset),
    .push      (bus.fill_vld),
    .push_data (fq_wdata),
    .pop       (op == ARB_WRITE),
    .match_idx (bus.lookup_idx),
    .head      (fq_head),
    .full      (fq_full),
    .empty     (fq_empty),
    .idx_match (fq_idx_match)
  );

  // Starve count is only non-zero with a non-empty queue, so a forced write always has a head.
  always_comb begin
    hazard       = |fq_idx_match;
    force_wr     = fq_full | (starve_q == STV_W'(STARVE_MAX));
    lookup_rdy_c = ~force_wr & ~hazard;
    op           = ARB_IDLE;
    if (bus.lookup_vld && lookup_rdy_c) begin
      op = ARB_READ;
    end else if (!fq_empty) begin
      op = ARB_WRITE;
    end

    starve_d = starve_q;
    if (op == ARB_WRITE || fq_empty) begin
      starve_d = '0;
    end else if (op == ARB_READ && starve_q != STV_W'(STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    rdreq_d  = (op == ARB_READ);
    wrreq_d  = (op == ARB_WRITE);
    clken_d  = rdreq_d | wrreq_d;
    index0_d = rdreq_d ? bus.lookup_idx  : '0;
    ptag_x_d = rdreq_d ? bus.lookup_ptag : '0;
    index1_d = wrreq_d ? fq_head.idx     : '0;
    wrway_d  = wrreq_d ? fq_head.way     : '0;
    wrtag_d  = wrreq_d ? fq_head.tag     : '0;
    rd_y_d   = rdreq_q;
    ptag_y_d = ptag_x_q;
  end

  assign rdtag_y[0] = bus.dta_rdtag_w0_y;
  assign rdtag_y[1] = bus.dta_rdtag_w1_y;
  assign rdtag_y[2] = bus.dta_rdtag_w2_y;
  assign rdtag_y[3] = bus.dta_rdtag_w3_y;

  generate
    for (genvar gi = 0; gi < NWAYS; gi++) begin : g_cmp
      assign way_match[gi] = rdtag_y[gi][TAG_VLD_BIT] & (rdtag_y[gi][PTAG_W-1:0] == ptag_y_q);
    end
  endgenerate

  assign match_cnt = popcnt_ways(way_match);

  always_comb begin
    hit_vld_d  = rd_y_q;
    hit_way_d  = rd_y_q ? way_match : '0;
    hit_d      = rd_y_q & (match_cnt == 3'd1);
    multihit_d = rd_y_q & (match_cnt > 3'd1);
  end

  always_ff @(posedge l2clk) begin
    if (reset) begin
      starve_q   <= '0;
      rdreq_q    <= 1'b0;
      wrreq_q    <= 1'b0;
      clken_q    <= 1'b0;
      index0_q   <= '0;
      index1_q   <= '0;
      wrway_q    <= '0;
      wrtag_q    <= '0;
      ptag_x_q   <= '0;
      rd_y_q     <= 1'b0;
      ptag_y_q   <= '0;
      hit_vld_q  <= 1'b0;
      hit_way_q  <= '0;
      hit_q      <= 1'b0;
      multihit_q <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      rdreq_q    <= rdreq_d;
      wrreq_q    <= wrreq_d;
      clken_q    <= clken_d;
      index0_q   <= index0_d;
      index1_q   <= index1_d;
      wrway_q    <= wrway_d;
      wrtag_q    <= wrtag_d;
      ptag_x_q   <= ptag_x_d;
      rd_y_q     <= rd_y_d;
      ptag_y_q   <= ptag_y_d;
      hit_vld_q  <= hit_vld_d;
      hit_way_q  <= hit_way_d;
      hit_q      <= hit_d;
      multihit_q <= multihit_d;
    end
  end

  assign bus.lookup_rdy      = lookup_rdy_c;
  assign bus.fill_rdy        = ~fq_full;
  assign bus.dta_index0_x    = index0_q;
  assign bus.dta_index1_x    = index1_q;
  assign bus.dta_index_sel_x = wrreq_q;
  assign bus.dta_wrway_x     = wrway_q;
  assign bus.dta_rdreq_x     = rdreq_q;
  assign bus.dta_wrreq_x     = wrreq_q;
  assign bus.dta_wrtag_x     = wrtag_q;
  assign bus.dta_clken       = clken_q;
  assign bus.hit_vld_m       = hit_vld_q;
  assign bus.hit_way_m       = hit_way_q;
  assign bus.hit_m           = hit_q;
  assign bus.multihit_err_m  = multihit_q;

endmodule

// File: tb/tb_n2_dta_access_ctl.sv
// Directed scoreboard bench: stimulus queues expected array ops and hit results, a monitor checks them.
module tb_n2_dta_access_ctl;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [6:0]  idx;
    logic [1:0]  way;
    logic [29:0] tag;
  } op_t;

  typedef struct {
    int         cyc;
    logic [3:0] way;
    logic       hit;
    logic       multi;
  } hit_t;

  typedef logic [3:0][29:0] resp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_fail;
  logic mon_en;
  logic rd_prev;

  op_t   exp_op_q[$];
  hit_t  exp_hit_q[$];
  resp_t resp_q[$];

  n2_dta_access_ctl_if bus ();

  n2_dta_access_ctl dut (
    .l2clk (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input logic lv, input logic [6:0] lidx, input logic [28:0] lptag,
                      input logic fv, input logic [6:0] fidx, input logic [1:0] fway,
                      input logic [29:0] ftag, input logic exp_lrdy, input logic exp_frdy,
                      input logic r = 1'b0);
    @(posedge clk);
    #1;
    rst             = r;
    bus.lookup_vld  = lv;
    bus.lookup_idx  = lidx;
    bus.lookup_ptag = lptag;
    bus.fill_vld    = fv;
    bus.fill_idx    = fidx;
    bus.fill_way    = fway;
    bus.fill_tag    = ftag;
    @(negedge clk);
    chk("lookup_rdy", 64'(bus.lookup_rdy), 64'(exp_lrdy));
    chk("fill_rdy", 64'(bus.fill_rdy), 64'(exp_frdy));
    $display("cyc %0d: lv=%0d idx=0x%02h fv=%0d fidx=0x%02h rst=%0d lrdy=%0d frdy=%0d",
             cyc, lv, lidx, fv, fidx, r, bus.lookup_rdy, bus.fill_rdy);
  endtask

  task automatic idle();
    step(1'b0, 7'h00, 29'h0, 1'b0, 7'h00, 2'd0, 30'h0, 1'b1, 1'b1);
  endtask

  // The op issued in the current cycle appears on the X-stage outputs one cycle later.
  task automatic exp_rd(input logic [6:0] idx, input resp_t r);
    op_t e;
    e.cyc = cyc + 1; e.wr = 1'b0; e.idx = idx; e.way = 2'd0; e.tag = 30'h0;
    exp_op_q.push_back(e);
    resp_q.push_back(r);
  endtask

  task automatic exp_hit(input logic [3:0] way, input logic hit, input logic multi);
    hit_t h;
    h.cyc = cyc + 3; h.way = way; h.hit = hit; h.multi = multi;
    exp_hit_q.push_back(h);
  endtask

  task automatic exp_wr(input logic [6:0] idx, input logic [1:0] way, input logic [29:0] tag);
    op_t e;
    e.cyc = cyc + 1; e.wr = 1'b1; e.idx = idx; e.way = way; e.tag = tag;
    exp_op_q.push_back(e);
  endtask

  // Tag array model: returns the queued read data in the cycle after each rdreq_x.
  initial rd_prev = 1'b0;
  always @(negedge clk) begin
    resp_t r;
    r = '0;
    if (rd_prev && resp_q.size() > 0) r = resp_q.pop_front();
    bus.dta_rdtag_w0_y = r[0];
    bus.dta_rdtag_w1_y = r[1];
    bus.dta_rdtag_w2_y = r[2];
    bus.dta_rdtag_w3_y = r[3];
    rd_prev = bus.dta_rdreq_x;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_op_q.size() > 0 && exp_op_q[0].cyc < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL op_missing: no array op seen, required one at cycle %0d", exp_op_q[0].cyc);
        void'(exp_op_q.pop_front());
      end
      while (exp_hit_q.size() > 0 && exp_hit_q[0].cyc < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL hit_missing: no hit_vld_m seen, required one at cycle %0d", exp_hit_q[0].cyc);
        void'(exp_hit_q.pop_front());
      end

      if (bus.dta_rdreq_x || bus.dta_wrreq_x) begin
        if (exp_op_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL op_unexpected: rdreq=%0d wrreq=%0d at cycle %0d, required none",
                   bus.dta_rdreq_x, bus.dta_wrreq_x, cyc);
        end else begin
          op_t e;
          e = exp_op_q.pop_front();
          chk("op_cycle", 64'(cyc), 64'(e.cyc));
          chk("wrreq_x", 64'(bus.dta_wrreq_x), 64'(e.wr));
          chk("rdreq_x", 64'(bus.dta_rdreq_x), 64'(!e.wr));
          chk("index_sel_x", 64'(bus.dta_index_sel_x), 64'(e.wr));
          chk("clken", 64'(bus.dta_clken), 64'd1);
          if (e.wr) begin
            chk("index1_x", 64'(bus.dta_index1_x), 64'(e.idx));
            chk("wrway_x", 64'(bus.dta_wrway_x), 64'(e.way));
            chk("wrtag_x", 64'(bus.dta_wrtag_x), 64'(e.tag));
          end else begin
            chk("index0_x", 64'(bus.dta_index0_x), 64'(e.idx));
          end
          $display("cyc %0d: array op wr=%0d idx=0x%02h", cyc, e.wr, e.idx);
        end
      end else begin
        chk("idle_clken", 64'(bus.dta_clken), 64'd0);
      end

      if (bus.hit_vld_m) begin
        if (exp_hit_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL hit_unexpected: hit_vld_m=1 way=%b at cycle %0d, required none",
                   bus.hit_way_m, cyc);
        end else begin
          hit_t h;
          h = exp_hit_q.pop_front();
          chk("hit_cycle", 64'(cyc), 64'(h.cyc));
          chk("hit_way_m", 64'(bus.hit_way_m), 64'(h.way));
          chk("hit_m", 64'(bus.hit_m), 64'(h.hit));
          chk("multihit_err_m", 64'(bus.multihit_err_m), 64'(h.multi));
          $display("cyc %0d: hit way=%b hit=%0d multi=%0d", cyc, bus.hit_way_m, bus.hit_m,
                   bus.multihit_err_m);
        end
      end else begin
        chk("hit_idle_fields", 64'({bus.hit_way_m, bus.hit_m, bus.multihit_err_m}), 64'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    mon_en = 1'b0;
    rst    = 1'b1;
    bus.lookup_vld = 1'b0; bus.lookup_idx = '0; bus.lookup_ptag = '0;
    bus.fill_vld = 1'b0; bus.fill_idx = '0; bus.fill_way = '0; bus.fill_tag = '0;
    bus.dta_rdtag_w0_y = '0; bus.dta_rdtag_w1_y = '0;
    bus.dta_rdtag_w2_y = '0; bus.dta_rdtag_w3_y = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_lookup_rdy", 64'(bus.lookup_rdy), 64'd1);
    chk("rst_fill_rdy", 64'(bus.fill_rdy), 64'd1);
    chk("rst_rdreq_x", 64'(bus.dta_rdreq_x), 64'd0);
    chk("rst_wrreq_x", 64'(bus.dta_wrreq_x), 64'd0);
    chk("rst_clken", 64'(bus.dta_clken), 64'd0);
    chk("rst_index0_x", 64'(bus.dta_index0_x), 64'd0);
    chk("rst_hit_vld_m", 64'(bus.hit_vld_m), 64'd0);
    mon_en = 1'b1;

    // Single hit in way 2; way 3 holds the same tag but is invalid.
    step(1'b1, 7'h05, 29'h1ABCDEF0, 1'b0, 7'h00, 2'd0, 30'h0, 1'b1, 1'b1);
    exp_rd(7'h05, {30'h1ABCDEF0, 30'h3ABCDEF0, 30'h00000000, 30'h3ABCDEF1});
    exp_hit(4'b0100, 1'b1, 1'b0);
    idle();

    // Back-to-back lookups: double hit, no hit, all-way hit at the top set index.
    step(1'b1, 7'h06, 29'h0000123, 1'b0, 7'h00, 2'd0, 30'h0, 1'b1, 1'b1);
    exp_rd(7'h06, {30'h20000123, 30'h20000124, 30'h00000000, 30'h20000123});
    exp_hit(4'b1001, 1'b0, 1'b1);
    step(1'b1, 7'h07, 29'h1FFFFFFF, 1'b0, 7'h00, 2'd0, 30'h0, 1'b1, 1'b1);
    exp_rd(7'h07, {30'h20000000, 30'h20000000, 30'h1FFFFFFF, 30'h20000000});
    exp_hit(4'b0000, 1'b0, 1'b0);
    step(1'b1, 7'h7F, 29'h0000000, 1'b0, 7'h00, 2'd0, 30'h0, 1'b1, 1'b1);
    exp_rd(7'h7F, {30'h20000000, 30'h20000000, 30'h20000000, 30'h20000000});
    exp_hit(4'b1111, 1'b0, 1'b1);
    idle(); idle(); idle();

    // Lone fill: issued once it is the queue head with no competing lookup.
    step(1'b0, 7'h00, 29'h0, 1'b1, 7'h10, 2'd1, 30'h20000001, 1'b1, 1'b1);
    idle();
    exp_wr(7'h10, 2'd1, 30'h20000001);
    idle();

    // Back-to-back fills: enqueue and dequeue in the same cycle keep the queue at one entry.
    step(1'b0, 7'h00, 29'h0, 1'b1, 7'h11, 2'd2, 30'h3FFFFFFF, 1'b1, 1'b1);
    step(1'b0, 7'h00, 29'h0, 1'b1, 7'h12, 2'd3, 30'h00000000, 1'b1, 1'b1);
    exp_wr(7'h11, 2'd2, 30'h3FFFFFFF);
    idle();
    exp_wr(7'h12, 2'd3, 30'h00000000);
    idle();

    // Starvation: eight lookup wins against a pending fill, then the fill is forced.
    step(1'b0, 7'h00, 29'h0, 1'b1, 7'h20, 2'd3, 30'h2AAAAAAA, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 7'h40 + 7'(k), 29'(k), 1'b0, 7'h00, 2'd0, 30'h0, 1'b1, 1'b1);
      exp_rd(7'h40 + 7'(k), '0);
      exp_hit(4'b0000, 1'b0, 1'b0);
    end
    step(1'b1, 7'h48, 29'h48, 1'b0, 7'h00, 2'd0, 30'h0, 1'b0, 1'b1);
    exp_wr(7'h20, 2'd3, 30'h2AAAAAAA);
    step(1'b1, 7'h48, 29'h48, 1'b0, 7'h00, 2'd0, 30'h0, 1'b1, 1'b1);
    exp_rd(7'h48, {30'h0, 30'h0, 30'h0, 30'h20000048});
    exp_hit(4'b0001, 1'b1, 1'b0);
    idle(); idle(); idle();

    // Index hazard: lookup to a set with a pending write waits for the write.
    step(1'b0, 7'h00, 29'h0, 1'b1, 7'h33, 2'd0, 30'h00000033, 1'b1, 1'b1);
    step(1'b1, 7'h33, 29'h33, 1'b0, 7'h00, 2'd0, 30'h0, 1'b0, 1'b1);
    exp_wr(7'h33, 2'd0, 30'h00000033);
    step(1'b1, 7'h33, 29'h33, 1'b0, 7'h00, 2'd0, 30'h0, 1'b1, 1'b1);
    exp_rd(7'h33, {30'h0, 30'h0, 30'h20000033, 30'h0});
    exp_hit(4'b0010, 1'b1, 1'b0);
    idle(); idle(); idle();

    // Fill queue fills up behind two lookups, then reset drops everything in flight.
    step(1'b1, 7'h60, 29'h60, 1'b1, 7'h50, 2'd0, 30'h20000050, 1'b1, 1'b1);
    exp_rd(7'h60, '0);
    step(1'b1, 7'h61, 29'h61, 1'b1, 7'h51, 2'd1, 30'h20000051, 1'b1, 1'b1);
    exp_rd(7'h61, '0);
    step(1'b1, 7'h62, 29'h62, 1'b1, 7'h52, 2'd2, 30'h20000052, 1'b0, 1'b0, 1'b1);
    idle();
    chk("post_rst_rdreq_x", 64'(bus.dta_rdreq_x), 64'd0);
    chk("post_rst_wrreq_x", 64'(bus.dta_wrreq_x), 64'd0);
    chk("post_rst_hit_vld_m", 64'(bus.hit_vld_m), 64'd0);
    idle(); idle(); idle(); idle();

    chk("exp_op_left", 64'(exp_op_q.size()), 64'd0);
    chk("exp_hit_left", 64'(exp_hit_q.size()), 64'd0);
    chk("resp_left", 64'(resp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
